// File: rtl/cpu_clk_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cpu_clk_pkg
//   Shared definitions for the CPU clock-enable controller:
//   - state_t      : controller FSM state encoding (2 bits)
//   - DEF_*        : default parameter values for board builds
// -----------------------------------------------------------------------------
package cpu_clk_pkg;

    typedef enum logic [1:0] {
        ST_RUN       = 2'b00,
        ST_STEP_IDLE = 2'b01,
        ST_STEP_FIRE = 2'b10
    } state_t;

    localparam int unsigned DEF_DEB_W    = 20;
    localparam int unsigned DEF_FAST_EXP = 21;
    localparam int unsigned DEF_SLOW_EXP = 29;
    localparam int unsigned DEF_CNT_W    = 16;

endpackage

// File: rtl/cpu_clk_ctrl_if.sv
// -----------------------------------------------------------------------------
// cpu_clk_ctrl_if
//   Board-side signal bundle of the CPU clock-enable controller.
//   SW15      : rate select (0 = fast, 1 = slow), raw async switch
//   SW_STEP   : mode select (0 = run, 1 = single-step), raw async switch
//   BTN_STEP  : raw step push-button, active-high, bouncy
//   CPU_CE    : one-cycle clock-enable pulse to the CPU
//   CE_COUNT  : number of CPU_CE pulses issued since reset (wraps)
//   MODE_STEP : high while the controller is in a step state
//   BTN_DB    : debounced button level
//   master = board/stimulus side, slave = controller side.
// -----------------------------------------------------------------------------
interface cpu_clk_ctrl_if #(
    parameter int unsigned CNT_W = cpu_clk_pkg::DEF_CNT_W
);

    logic             SW15;
    logic             SW_STEP;
    logic             BTN_STEP;
    logic             CPU_CE;
    logic [CNT_W-1:0] CE_COUNT;
    logic             MODE_STEP;
    logic             BTN_DB;

    modport master (
        output SW15, SW_STEP, BTN_STEP,
        input  CPU_CE, CE_COUNT, MODE_STEP, BTN_DB
    );

    modport slave (
        input  SW15, SW_STEP, BTN_STEP,
        output CPU_CE, CE_COUNT, MODE_STEP, BTN_DB
    );

endinterface

// File: rtl/cpu_clk_ctrl_btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
//   2-FF synchroniser, counter-based debouncer and rising-edge detector for a
//   raw push-button. The synchronised level must differ from the accepted
//   level for 2^DEB_W consecutive cycles before it is accepted; any bounce
//   back to the accepted level restarts the count.
//   clk     : clock
//   rst     : synchronous active-high reset
//   btn_i   : raw asynchronous button
//   db_o    : debounced level
//   press_o : one-cycle pulse on the debounced 0->1 edge
// -----------------------------------------------------------------------------
module btn_debounce import cpu_clk_pkg::*; #(
    parameter int unsigned DEB_W = DEF_DEB_W
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic db_o,
    output logic press_o
);

    logic             meta_q;
    logic             btn_s_q;
    logic             db_q, db_d;
    logic             db_prev_q;
    logic [DEB_W-1:0] cnt_q, cnt_d;

    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        if (btn_s_q != db_q) begin
            if (cnt_q == '1) begin
                // Level has differed for the full window: accept it.
                db_d  = btn_s_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q    <= 1'b0;
            btn_s_q   <= 1'b0;
            db_q      <= 1'b0;
            db_prev_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            meta_q    <= btn_i;
            btn_s_q   <= meta_q;
            db_q      <= db_d;
            db_prev_q <= db_q;
            cnt_q     <= cnt_d;
        end
    end

    assign db_o    = db_q;
    assign press_o = db_q & ~db_prev_q;

endmodule

// File: rtl/cpu_clk_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_clk_ctrl
//   CPU clock-enable controller. In run mode CPU_CE pulses once every
//   2^FAST_EXP or 2^SLOW_EXP cycles (SW15); in step mode it pulses exactly
//   once per debounced press of BTN_STEP.
//   CLK : board clock
//   RST : synchronous active-high reset
//   bus : board-side signals (slave modport), see cpu_clk_ctrl_if
// -----------------------------------------------------------------------------
module cpu_clk_ctrl import cpu_clk_pkg::*; #(
    parameter int unsigned DEB_W    = DEF_DEB_W,
    parameter int unsigned FAST_EXP = DEF_FAST_EXP,
    parameter int unsigned SLOW_EXP = DEF_SLOW_EXP,
    parameter int unsigned CNT_W    = DEF_CNT_W
) (
    input  logic          CLK,
    input  logic          RST,
    cpu_clk_ctrl_if.slave bus
);

    // Switch synchronisers
    logic sw15_meta_q, sw15_s_q;
    logic step_meta_q, step_s_q;

    // Free-running divider; shared by both rates so a rate change keeps phase
    logic [SLOW_EXP-1:0] div_q, div_d;
    logic                tick;

    // Debounced button
    logic btn_db;
    logic press;

    // FSM and outputs
    state_t           state_q, state_d;
    logic             ce_q, ce_d;
    logic             mode_q, mode_d;
    logic [CNT_W-1:0] count_q, count_d;

    btn_debounce #(
        .DEB_W(DEB_W)
    ) u_btn_debounce (
        .clk     (CLK),
        .rst     (RST),
        .btn_i   (bus.BTN_STEP),
        .db_o    (btn_db),
        .press_o (press)
    );

    // Tick when the selected low field of the divider is all-ones.
    always_comb begin
        div_d = div_q + 1'b1;
        tick  = sw15_s_q ? (&div_q) : (&div_q[FAST_EXP-1:0]);
    end

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            sw15_meta_q <= 1'b0;
            sw15_s_q    <= 1'b0;
            step_meta_q <= 1'b0;
            step_s_q    <= 1'b0;
            div_q       <= '0;
            state_q     <= ST_RUN;
            ce_q        <= 1'b0;
            mode_q      <= 1'b0;
            count_q     <= '0;
        end else begin
            sw15_meta_q <= bus.SW15;
            sw15_s_q    <= sw15_meta_q;
            step_meta_q <= bus.SW_STEP;
            step_s_q    <= step_meta_q;
            div_q       <= div_d;
            state_q     <= state_d;
            ce_q        <= ce_d;
            mode_q      <= mode_d;
            count_q     <= count_d;
        end
    end

    // Next-state logic. Leaving step mode wins over a coincident press.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (step_s_q) state_d = ST_STEP_IDLE;
            end
            ST_STEP_IDLE: begin
                if (!step_s_q)  state_d = ST_RUN;
                else if (press) state_d = ST_STEP_FIRE;
            end
            ST_STEP_FIRE: begin
                state_d = step_s_q ? ST_STEP_IDLE : ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Output logic. A press seen in RUN is simply dropped; a press cannot
    // arrive in STEP_FIRE because the edge was consumed one cycle earlier.
    always_comb begin
        ce_d = 1'b0;
        case (state_q)
            ST_RUN:       ce_d = tick & ~step_s_q;
            ST_STEP_IDLE: ce_d = step_s_q & press;
            default:      ce_d = 1'b0;
        endcase
        mode_d  = (state_d != ST_RUN);
        count_d = count_q + CNT_W'(ce_d);
    end

    assign bus.CPU_CE    = ce_q;
    assign bus.CE_COUNT  = count_q;
    assign bus.MODE_STEP = mode_q;
    assign bus.BTN_DB    = btn_db;

endmodule
